// File: rtl/press_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : press_event_decoder
// Description : Classifies presses of a debounced button into single-cycle
//               short / long / double press events for the parking
//               controller. Fully synchronous, one clock domain.
// Ports       : clk         - system clock, rising edge
//               rst         - synchronous active-high reset
//               inButton    - debounced button level, 1 = pressed
//               shortPress  - one-cycle pulse, short press classified
//               longPress   - one-cycle pulse, long press classified
//               doublePress - one-cycle pulse, second press inside gap
//               held        - level, high while a long press is held
//               eventCount  - total events emitted, wraps modulo 2^EVT_W
// Revision    : 1.0 - initial release
// ============================================================================
module press_event_decoder #(
    parameter int LONG_CYCLES = 50,
    parameter int GAP_CYCLES  = 20,
    parameter int CNT_W       = 16,
    parameter int EVT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inButton,
    output logic             shortPress,
    output logic             longPress,
    output logic             doublePress,
    output logic             held,
    output logic [EVT_W-1:0] eventCount
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        GAP       = 3'd2,
        HOLD_LONG = 3'd3,
        WAIT_REL  = 3'd4
    } state_t;

    // Terminal counts: the counter already holds the number of samples seen,
    // so the deciding sample arrives while cnt equals N-1.
    localparam logic [CNT_W-1:0] c_longLast = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gapLast  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cntOne   = CNT_W'(1);
    localparam logic [EVT_W-1:0] c_evtOne   = EVT_W'(1);

    state_t           r_state;
    state_t           w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_shortPress;
    logic             r_longPress;
    logic             r_doublePress;
    logic             r_held;
    logic [EVT_W-1:0] r_eventCount;
    logic             w_shortNext;
    logic             w_longNext;
    logic             w_doubleNext;
    logic             w_heldNext;
    logic             w_anyEvent;

    // ------------------------------------------------------------------
    // State, counter and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_shortPress  <= 1'b0;
            r_longPress   <= 1'b0;
            r_doublePress <= 1'b0;
            r_held        <= 1'b0;
            r_eventCount  <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_cnt         <= w_cntNext;
            r_shortPress  <= w_shortNext;
            r_longPress   <= w_longNext;
            r_doublePress <= w_doubleNext;
            r_held        <= w_heldNext;
            if (w_anyEvent) begin
                r_eventCount <= r_eventCount + c_evtOne;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_shortNext  = 1'b0;
        w_longNext   = 1'b0;
        w_doubleNext = 1'b0;
        w_heldNext   = 1'b0;

        case (r_state)
            IDLE: begin
                if (inButton) begin
                    w_stateNext = PRESS1;
                    w_cntNext   = c_cntOne;
                end
            end

            PRESS1: begin
                if (inButton) begin
                    if (r_cnt == c_longLast) begin
                        w_longNext  = 1'b1;
                        w_heldNext  = 1'b1;
                        w_stateNext = HOLD_LONG;
                        w_cntNext   = '0;
                    end else begin
                        w_cntNext = r_cnt + c_cntOne;
                    end
                end else begin
                    // First low sample of the gap window is counted here.
                    w_stateNext = GAP;
                    w_cntNext   = c_cntOne;
                end
            end

            GAP: begin
                if (inButton) begin
                    w_doubleNext = 1'b1;
                    w_stateNext  = WAIT_REL;
                    w_cntNext    = '0;
                end else if (r_cnt == c_gapLast) begin
                    w_shortNext = 1'b1;
                    w_stateNext = IDLE;
                    w_cntNext   = '0;
                end else begin
                    w_cntNext = r_cnt + c_cntOne;
                end
            end

            HOLD_LONG: begin
                // Release ends the hold silently; a quick re-press starts
                // fresh from IDLE and can never count as a double press.
                if (inButton) begin
                    w_heldNext = 1'b1;
                end else begin
                    w_stateNext = IDLE;
                end
            end

            WAIT_REL: begin
                // Second press of a double: duration is irrelevant.
                if (!inButton) begin
                    w_stateNext = IDLE;
                end
            end

            default: begin
                w_stateNext = IDLE;
                w_cntNext   = '0;
            end
        endcase
    end

    // Paths above are mutually exclusive, so at most one event per cycle.
    assign w_anyEvent = w_shortNext | w_longNext | w_doubleNext;

    assign shortPress  = r_shortPress;
    assign longPress   = r_longPress;
    assign doublePress = r_doublePress;
    assign held        = r_held;
    assign eventCount  = r_eventCount;

endmodule
`default_nettype wire

// File: tb/tb_press_event_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_press_event_decoder
// Description : Directed self-checking bench for press_event_decoder.
//               Each step drives one input sample, waits for the edge and
//               compares {shortPress,longPress,doublePress,held} and
//               eventCount against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_press_event_decoder;

    localparam int LONG_CYCLES = 50;
    localparam int GAP_CYCLES  = 20;
    localparam int CNT_W       = 16;
    localparam int EVT_W       = 8;

    // Expected output vectors, ordered {short, long, double, held}
    localparam logic [3:0] c_none   = 4'b0000;
    localparam logic [3:0] c_short  = 4'b1000;
    localparam logic [3:0] c_long   = 4'b0101;
    localparam logic [3:0] c_double = 4'b0010;
    localparam logic [3:0] c_held   = 4'b0001;

    logic             clk;
    logic             rst;
    logic             inButton;
    logic             shortPress;
    logic             longPress;
    logic             doublePress;
    logic             held;
    logic [EVT_W-1:0] eventCount;

    int               errors;
    int               checks;
    logic [EVT_W-1:0] expCnt;

    press_event_decoder #(
        .LONG_CYCLES (LONG_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .CNT_W       (CNT_W),
        .EVT_W       (EVT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inButton    (inButton),
        .shortPress  (shortPress),
        .longPress   (longPress),
        .doublePress (doublePress),
        .held        (held),
        .eventCount  (eventCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One sample: drive inButton, let the edge happen, check 1 ns later.
    task automatic step(input logic b, input logic [3:0] exp, input string tag);
        inButton = b;
        @(posedge clk);
        #1;
        if (|exp[3:1]) expCnt = expCnt + 1'b1;
        chk({tag, " outputs"}, {28'd0, shortPress, longPress, doublePress, held}, {28'd0, exp});
        chk({tag, " eventCount"}, {24'd0, eventCount}, {24'd0, expCnt});
    endtask

    // n samples at level b; all but the last expect expMid, last expects expLast.
    task automatic seg(input logic b, input int n, input logic [3:0] expMid,
                       input logic [3:0] expLast, input string tag);
        for (int i = 1; i <= n; i++) begin
            step(b, (i == n) ? expLast : expMid, tag);
        end
    endtask

    task automatic resetSteps(input int n, input logic b, input string tag);
        rst = 1'b1;
        expCnt = '0;
        for (int i = 0; i < n; i++) begin
            step(b, c_none, tag);
        end
        rst = 1'b0;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        expCnt   = '0;
        rst      = 1'b1;
        inButton = 1'b1;

        // 1. Reset with button held, then release: press counts from first edge.
        resetSteps(3, 1'b1, "t1 reset");
        seg(1'b1, LONG_CYCLES - 1, c_none, c_none, "t1 high");
        step(1'b1, c_long, "t1 long");
        step(1'b0, c_none, "t1 release");
        seg(1'b0, 3, c_none, c_none, "t1 idle");

        // 2. Short press: 10 high, 20 low.
        seg(1'b1, 10, c_none, c_none, "t2 high");
        seg(1'b0, GAP_CYCLES, c_none, c_short, "t2 gap");
        step(1'b0, c_none, "t2 after");

        // 3. Long press: 60 high, then low.
        seg(1'b1, LONG_CYCLES - 1, c_none, c_none, "t3 high");
        step(1'b1, c_long, "t3 long");
        seg(1'b1, 10, c_held, c_held, "t3 hold");
        step(1'b0, c_none, "t3 release");
        seg(1'b0, GAP_CYCLES + 2, c_none, c_none, "t3 quiet");

        // 4. Double press: high 5, low 10, high 5, low 30.
        seg(1'b1, 5, c_none, c_none, "t4 high1");
        seg(1'b0, 10, c_none, c_none, "t4 low1");
        step(1'b1, c_double, "t4 double");
        seg(1'b1, 4, c_none, c_none, "t4 high2");
        seg(1'b0, 30, c_none, c_none, "t4 low2");

        // 5. Two short presses separated by a full gap window.
        seg(1'b1, 5, c_none, c_none, "t5 high1");
        seg(1'b0, GAP_CYCLES, c_none, c_short, "t5 gap1");
        seg(1'b1, 5, c_none, c_none, "t5 high2");
        seg(1'b0, GAP_CYCLES, c_none, c_short, "t5 gap2");
        chk("t5 total", {24'd0, eventCount}, 32'd6);

        // 6a. Reset at 40th high sample, release with button still high.
        seg(1'b1, 39, c_none, c_none, "t6 high");
        resetSteps(2, 1'b1, "t6 reset");
        seg(1'b1, LONG_CYCLES - 1, c_none, c_none, "t6 high2");
        step(1'b1, c_long, "t6 long");
        step(1'b0, c_none, "t6 release");

        // 6b. 256 one-cycle presses after reset: count wraps to 0.
        resetSteps(1, 1'b0, "t6 reset2");
        for (int k = 0; k < 256; k++) begin
            step(1'b1, c_none, "t6 pulse");
            seg(1'b0, GAP_CYCLES, c_none, c_short, "t6 pulse gap");
            if (k == 254) chk("t6 count255", {24'd0, eventCount}, 32'd255);
        end
        chk("t6 wrap", {24'd0, eventCount}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/press_event_decoder.md
Name: press_event_decoder

Overview:
- Consumes the debounced button level from the debouncer and classifies each press into one of three single-cycle events: short press, long press, or double press.
- Sits between the debouncer and the parking controller logic, e.g. gate open/close, ticket request and service mode.
- Fully synchronous, one clock domain.
- Input is already debounced, so no glitch filtering is done here.

Parameters:
LONG_CYCLES, 50, consecutive high samples needed to declare a long press (must be ≥2)
GAP_CYCLES, 20, consecutive low samples after a release that close a short press (must be ≥2)
CNT_W, 16, width of the internal cycle counter (must hold max(LONG_CYCLES, GAP_CYCLES))
EVT_W, 8, width of the event counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
inButton  input  1  debounced button level, 1 = pressed
shortPress  output  1  one-cycle pulse, short press classified
longPress  output  1  one-cycle pulse, long press classified
doublePress  output  1  one-cycle pulse, second press started within the gap window
held  output  1  level, high while a long press is still held
eventCount  output  EVT_W  total events emitted, wraps modulo 2^EVT_W

Behaviour:
- All outputs are registered. Reset values: shortPress, longPress, doublePress, held = 0; eventCount = 0; state = IDLE; cnt = 0.
- rst takes priority over everything. Asserting it mid-operation abandons the current press with no event.
- After rst is released with inButton still high, the next edge treats it as a new press.
- "Sample" means the value of inButton at a rising clk edge. Event outputs go high for exactly one cycle following the deciding edge.
- At most one event pulse per cycle.
- eventCount increments on the same edge an event pulse is set.
- FSM states: IDLE, PRESS1, GAP, HOLD_LONG, WAIT_REL.
- IDLE:
  - sample 1 → PRESS1, cnt = 1.
  - sample 0 → stay in IDLE.
- PRESS1:
  - sample 1 and cnt == LONG_CYCLES-1 → set longPress and held, go to HOLD_LONG.
  - sample 1 otherwise → cnt++.
  - sample 0 → GAP, cnt = 1.
  - Result: longPress fires on the LONG_CYCLES-th consecutive high sample.
- GAP:
  - sample 1 → set doublePress, go to WAIT_REL. This can happen on low samples 2..GAP_CYCLES of the window.
  - sample 0 and cnt == GAP_CYCLES-1 → set shortPress, go to IDLE.
  - sample 0 otherwise → cnt++.
  - Result: shortPress fires on the GAP_CYCLES-th consecutive low sample.
- HOLD_LONG:
  - held stays 1.
  - sample 0 → held = 0, go to IDLE. No event on release.
- WAIT_REL:
  - Ignores press duration; no long press is possible from here.
  - sample 0 → IDLE, no event.
- A one-cycle high pulse is a valid press and follows the short-press path.
- A short press immediately followed by a new press after the window closed enters PRESS1 fresh. It is never classified as a double press.
- cnt never exceeds max(LONG_CYCLES, GAP_CYCLES)-1, so there is no counter wrap.
- eventCount wraps from 2^EVT_W-1 to 0.
- Long press followed by a quick re-press is not a double press: HOLD_LONG returns to IDLE.

Test Plan:
(Defaults; 10 ns clock.)
1. Reset held 3 cycles with inButton=1, then released → all outputs 0 during reset and eventCount=0. Press then counts from the first post-reset edge; longPress arrives on the 50th high sample after release.
2. High for 10 samples, then low → no event for 19 low samples. shortPress=1 for one cycle after the 20th low sample; eventCount=1; longPress, doublePress and held stay 0.
3. High for 60 samples, then low → longPress pulse and held=1 after the 50th high sample. held stays 1 through sample 60 and clears on the first low sample. No shortPress; eventCount=1.
4. High 5, low 10, high 5, low 30 → doublePress pulse after the first high sample of the second press. No shortPress at any time; no event on the second release; eventCount=1.
5. High 5, low 20, high 5, low 20 → shortPress after the 20th low sample, then a second shortPress after the next 20 low samples. No doublePress; eventCount=2.
6. Assert rst at the 40th high sample of a press, then release with inButton still high → no longPress at the original 50th sample. longPress fires 50 samples after reset release. 256 short presses in a row → eventCount wraps to 0.
